// File: rtl/neuromod_update_scheduler.sv
// Update scheduler for the neurotransmitter resource counters.
// Latches per-channel inc/dec/fast requests and runs a programmable tick.
// On each tick with work pending, one channel is granted a single-cycle
// inc or dec strobe (plus fast qualifier). Priority: starving channels first,
// then fast requests round-robin, then any pending request round-robin.
module neuromod_update_scheduler #(
    parameter int N_CH       = 4,
    parameter int PRESCALE_W = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [PRESCALE_W-1:0]   period,
    input  logic [N_CH-1:0]         req_inc,
    input  logic [N_CH-1:0]         req_dec,
    input  logic [N_CH-1:0]         req_fast,
    output logic [N_CH-1:0]         grant_inc,
    output logic [N_CH-1:0]         grant_dec,
    output logic [N_CH-1:0]         grant_fast,
    output logic [$clog2(N_CH)-1:0] grant_ch,
    output logic                    tick,
    output logic                    overrun
);
    localparam int         CH_W     = $clog2(N_CH);
    localparam logic [3:0] STARVE_L = 4'(STARVE_MAX);
    localparam logic [3:0] AGE_SAT  = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_ISSUE} state_t;

    state_t                state_q;
    logic [PRESCALE_W-1:0] cnt_q;
    logic                  tick_q;
    logic                  overrun_q;
    logic [N_CH-1:0]       pend_q, pend_d;
    logic [N_CH-1:0]       dir_q, dir_d;      // 1 = increment, 0 = decrement
    logic [N_CH-1:0]       fast_q, fast_d;
    logic [3:0]            age_q [N_CH];
    logic [CH_W-1:0]       ptr_q;
    logic [CH_W-1:0]       grant_ch_q;
    logic [N_CH-1:0]       grant_inc_q, grant_dec_q, grant_fast_q;

    logic [N_CH-1:0]       req_ok;            // exactly one direction requested
    logic [N_CH-1:0]       svc_clr;           // winner being served this cycle
    logic [N_CH-1:0]       win_onehot;
    logic [CH_W-1:0]       win_idx;
    logic                  win_found;

    assign grant_inc  = grant_inc_q;
    assign grant_dec  = grant_dec_q;
    assign grant_fast = grant_fast_q;
    assign grant_ch   = grant_ch_q;
    assign tick       = tick_q;
    assign overrun    = overrun_q;

    // Prescaler: free count 0..period, one-cycle tick after reaching period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (!enable) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == period) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            // Wraps through the maximum if period was lowered below cnt.
            cnt_q  <= cnt_q + PRESCALE_W'(1);
            tick_q <= 1'b0;
        end
    end

    // Winner selection: starving lowest index, else fast RR, else plain RR.
    always_comb begin
        logic [CH_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (pend_q[k] && (age_q[k] >= STARVE_L)) begin
                win_found = 1'b1;
                win_idx   = CH_W'(k);
            end
        end
        for (int k = 1; k <= N_CH; k++) begin
            idx = CH_W'((int'(ptr_q) + k) % N_CH);
            if (!win_found && pend_q[idx] && fast_q[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
        for (int k = 1; k <= N_CH; k++) begin
            idx = CH_W'((int'(ptr_q) + k) % N_CH);
            if (!win_found && pend_q[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
        win_onehot = win_found ? (N_CH'(1) << win_idx) : '0;
    end

    // Pending latch next state: a new request beats a same-cycle service clear.
    always_comb begin
        req_ok  = req_inc ^ req_dec;
        svc_clr = (state_q == S_ARB) ? win_onehot : '0;
        pend_d  = (pend_q & ~svc_clr) | req_ok;
        fast_d  = (fast_q & ~svc_clr) | (req_ok & req_fast);
        dir_d   = (dir_q & ~req_ok) | (req_ok & req_inc);
    end

    // Pending request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            fast_q <= '0;
            dir_q  <= '0;
        end else begin
            pend_q <= pend_d;
            fast_q <= fast_d;
            dir_q  <= dir_d;
        end
    end

    // Grant FSM with registered strobes, ages, round-robin pointer and overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_inc_q  <= '0;
            grant_dec_q  <= '0;
            grant_fast_q <= '0;
            grant_ch_q   <= '0;
            overrun_q    <= 1'b0;
            ptr_q        <= CH_W'(N_CH - 1);
            for (int i = 0; i < N_CH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            grant_inc_q  <= '0;
            grant_dec_q  <= '0;
            grant_fast_q <= '0;
            // Ticks are never queued: one landing mid-grant is lost.
            if (tick_q && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (tick_q && (|pend_q)) begin
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (win_found) begin
                        grant_inc_q  <= win_onehot & dir_q;
                        grant_dec_q  <= win_onehot & ~dir_q;
                        grant_fast_q <= win_onehot & fast_q;
                        grant_ch_q   <= win_idx;
                        ptr_q        <= win_idx;
                        for (int i = 0; i < N_CH; i++) begin
                            if (win_onehot[i]) begin
                                age_q[i] <= '0;
                            end else if (pend_q[i] && (age_q[i] != AGE_SAT)) begin
                                age_q[i] <= age_q[i] + 4'd1;
                            end
                        end
                    end
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuromod_update_scheduler.sv
// Directed bench for neuromod_update_scheduler (N_CH=4, STARVE_MAX=3).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_neuromod_update_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] period;
    logic [3:0] req_inc, req_dec, req_fast;
    logic [3:0] grant_inc, grant_dec, grant_fast;
    logic [1:0] grant_ch;
    logic       tick, overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    neuromod_update_scheduler #(
        .N_CH       (4),
        .PRESCALE_W (8),
        .STARVE_MAX (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .period     (period),
        .req_inc    (req_inc),
        .req_dec    (req_dec),
        .req_fast   (req_fast),
        .grant_inc  (grant_inc),
        .grant_dec  (grant_dec),
        .grant_fast (grant_fast),
        .grant_ch   (grant_ch),
        .tick       (tick),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        enable   = 1'b0;
        req_inc  = '0;
        req_dec  = '0;
        req_fast = '0;
        step(2);
        rst = 1'b0;
    endtask

    // Returns at the first falling edge (current one included) with tick high.
    task automatic wait_tick(input string tag, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (tick) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    // Advances to the next falling edge that shows any grant strobe.
    task automatic wait_grant(input string tag, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((|grant_inc) || (|grant_dec)) begin
                seen = 1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
        if (seen == 1)
            $display("grant ch=%0d inc=%b dec=%b fast=%b", grant_ch, grant_inc, grant_dec, grant_fast);
    endtask

    task automatic count_grants(input int n, output int g, output int t);
        g = 0;
        t = 0;
        repeat (n) begin
            @(negedge clk);
            if ((|grant_inc) || (|grant_dec)) g++;
            if (tick) t++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, t;
        int rr_exp [6] = '{0, 1, 2, 3, 0, 1};

        // Reset values
        rst = 1'b1; enable = 1'b0; period = 8'd3;
        req_inc = '0; req_dec = '0; req_fast = '0;
        step(1);
        chk("rst_grant_inc",  32'(grant_inc),  32'h0);
        chk("rst_grant_dec",  32'(grant_dec),  32'h0);
        chk("rst_grant_fast", 32'(grant_fast), 32'h0);
        chk("rst_grant_ch",   32'(grant_ch),   32'h0);
        chk("rst_tick",       32'(tick),       32'h0);
        chk("rst_overrun",    32'(overrun),    32'h0);
        rst = 1'b0; enable = 1'b1;

        // Reset during ISSUE: strobes drop at once, pending ch1 is discarded
        req_inc = 4'b0011; step(1); req_inc = '0;
        wait_grant("rmid_wait", 16);
        chk("rmid_first_inc", 32'(grant_inc), 32'h1);
        rst = 1'b1;
        #1;
        chk("rmid_async_inc",  32'(grant_inc),  32'h0);
        chk("rmid_async_dec",  32'(grant_dec),  32'h0);
        chk("rmid_async_fast", 32'(grant_fast), 32'h0);
        chk("rmid_async_ch",   32'(grant_ch),   32'h0);
        step(1);
        rst = 1'b0;
        count_grants(20, g, t);
        chk("rmid_no_grant_20", 32'(g), 32'd0);

        // Single request, period 3
        req_inc = 4'b0100; step(1); req_inc = '0;
        wait_tick("single_tick", 10);
        step(1);
        chk("single_arb_inc",  32'(grant_inc), 32'h0);
        chk("single_arb_tick", 32'(tick),      32'h0);
        step(1);
        chk("single_grant_inc",  32'(grant_inc),  32'h4);
        chk("single_grant_dec",  32'(grant_dec),  32'h0);
        chk("single_grant_fast", 32'(grant_fast), 32'h0);
        chk("single_grant_ch",   32'(grant_ch),   32'h2);
        $display("grant ch=%0d inc=%b dec=%b fast=%b", grant_ch, grant_inc, grant_dec, grant_fast);
        step(1);
        chk("single_strobe_drop", 32'(grant_inc), 32'h0);
        chk("single_ch_held",     32'(grant_ch),  32'h2);
        step(1);
        chk("single_tick_period", 32'(tick), 32'h1);
        count_grants(16, g, t);
        chk("single_no_more_grants", 32'(g), 32'd0);
        chk("single_tick_count",     32'(t), 32'd4);

        // Round-robin with all channels held, period 7
        do_reset();
        period = 8'd7; enable = 1'b1; req_inc = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_grant($sformatf("rr_wait_%0d", k), 20);
            chk($sformatf("rr_inc_%0d", k), 32'(grant_inc), 32'd1 << rr_exp[k]);
            chk($sformatf("rr_ch_%0d", k),  32'(grant_ch),  32'(rr_exp[k]));
        end
        chk("rr_overrun", 32'(overrun), 32'h0);
        req_inc = '0;

        // Fast priority versus starvation
        do_reset();
        period = 8'd3; enable = 1'b1;
        req_dec = 4'b0011; req_fast = 4'b0010;
        step(1);
        req_dec = 4'b0010;
        for (int k = 1; k <= 3; k++) begin
            wait_grant($sformatf("starve_wait_%0d", k), 12);
            chk($sformatf("starve_dec_%0d", k),  32'(grant_dec),  32'h2);
            chk($sformatf("starve_fast_%0d", k), 32'(grant_fast), 32'h2);
            chk($sformatf("starve_inc_%0d", k),  32'(grant_inc),  32'h0);
        end
        wait_grant("starve_wait_4", 12);
        chk("starve_dec_4",  32'(grant_dec),  32'h1);
        chk("starve_fast_4", 32'(grant_fast), 32'h0);
        chk("starve_ch_4",   32'(grant_ch),   32'h0);
        req_dec = '0; req_fast = '0;

        // Direction rules on ch3
        do_reset();
        period = 8'd3; enable = 1'b1;
        req_inc = 4'b1000; req_dec = 4'b1000;
        step(1);
        req_inc = '0; req_dec = '0;
        count_grants(12, g, t);
        chk("dir_both_no_grant", 32'(g), 32'd0);
        req_inc = 4'b1000; step(1);
        req_inc = '0; req_dec = 4'b1000; step(1);
        req_dec = '0;
        wait_grant("dir_wait", 12);
        chk("dir_last_dec", 32'(grant_dec), 32'h8);
        chk("dir_no_inc",   32'(grant_inc), 32'h0);
        count_grants(12, g, t);
        chk("dir_single_grant", 32'(g), 32'd0);

        // Overrun with period 0
        do_reset();
        period = 8'd0; req_inc = 4'b0001; enable = 1'b1;
        step(2);
        chk("ovr_before", 32'(overrun), 32'h0);
        step(1);
        chk("ovr_set", 32'(overrun), 32'h1);
        step(10);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        req_inc = '0;

        // Enable low holds off ticks; latched requests served afterwards
        do_reset();
        period = 8'd3; enable = 1'b0;
        req_inc = 4'b0010; req_dec = 4'b0100;
        step(1);
        req_inc = '0; req_dec = '0;
        count_grants(15, g, t);
        chk("en_off_grants", 32'(g), 32'd0);
        chk("en_off_ticks",  32'(t), 32'd0);
        enable = 1'b1;
        wait_grant("en_wait_1", 12);
        chk("en_inc_1", 32'(grant_inc), 32'h2);
        chk("en_ch_1",  32'(grant_ch),  32'h1);
        wait_grant("en_wait_2", 12);
        chk("en_dec_2", 32'(grant_dec), 32'h4);
        chk("en_ch_2",  32'(grant_ch),  32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
